// File: rtl/banked_sample_buffer.sv
// Record/playback sample buffer over NUM_BANKS single-port RAM banks addressed as one linear space.
// Self-managed write/read pointers, recorded length tracking and a 2-cycle playback pipeline.
module banked_sample_buffer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned BANK_ADDR_W = 14,
    parameter bit          USE_SPRAM   = 1'b1,
    localparam int unsigned ADDR_W     = $clog2(NUM_BANKS) + BANK_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              loop,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              play_req,
    output logic [DATA_W-1:0] sample_out,
    output logic              out_valid,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              busy,
    output logic              done
);
    localparam int unsigned SEL_W = $clog2(NUM_BANKS);
    localparam int unsigned SB    = (SEL_W == 0) ? 1 : SEL_W;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    length_q, length_d;
    logic               full_q, full_d, loop_q, loop_d, done_q, done_d;
    logic               rd_pend_q, rd_last_q, rd_last_d;
    logic               out_valid_q;
    logic [DATA_W-1:0]  sample_out_q;
    logic [SB-1:0]      wr_bank, rd_bank, rd_bank_q;
    logic               wr_en, rd_en;
    logic [DATA_W-1:0]  bank_dout [NUM_BANKS];

    if (SEL_W == 0) begin : g_one_bank
        assign wr_bank = '0;
        assign rd_bank = '0;
    end else begin : g_bank_sel
        assign wr_bank = wr_ptr_q[ADDR_W-1:BANK_ADDR_W];
        assign rd_bank = rd_ptr_q[ADDR_W-1:BANK_ADDR_W];
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        length_d  = length_q;
        full_d    = full_q;
        loop_d    = loop_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_last_d = 1'b0;
        done_d    = rd_pend_q & rd_last_q;
        case (state_q)
            IDLE: begin
                if (rec_start) begin
                    state_d  = RECORD;
                    wr_ptr_d = '0;
                    length_d = '0;
                    full_d   = 1'b0;
                end else if (play_start && (length_q != '0)) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                    loop_d   = loop;
                end
            end
            RECORD: begin
                // A stop in the same cycle as in_valid still commits the write.
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    length_d = length_q + (ADDR_W + 1)'(1);
                    if (wr_ptr_q == '1) begin
                        full_d  = 1'b1;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (play_req) begin
                    rd_en = 1'b1;
                    if ({1'b0, rd_ptr_q} == length_q - (ADDR_W + 1)'(1)) begin
                        if (loop_q) begin
                            rd_ptr_d = '0;
                        end else begin
                            state_d   = IDLE;
                            rd_last_d = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            length_q     <= '0;
            full_q       <= 1'b0;
            loop_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_bank_q    <= '0;
            out_valid_q  <= 1'b0;
            sample_out_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            length_q    <= length_d;
            full_q      <= full_d;
            loop_q      <= loop_d;
            done_q      <= done_d;
            rd_pend_q   <= rd_en;
            rd_last_q   <= rd_last_d;
            rd_bank_q   <= rd_bank;
            out_valid_q <= rd_pend_q;
            // Bank select travels with the read so the mux never sees the current address.
            if (rd_pend_q) begin
                sample_out_q <= bank_dout[rd_bank_q];
            end
        end
    end

`ifdef SYNTHESIS
    localparam bit SPRAM_EN = 1'b1;
`else
    localparam bit SPRAM_EN = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                   we, re;
        logic [BANK_ADDR_W-1:0] addr;
        assign we   = wr_en && (wr_bank == SB'(b));
        assign re   = rd_en && (rd_bank == SB'(b));
        assign addr = (state_q == RECORD) ? wr_ptr_q[BANK_ADDR_W-1:0] : rd_ptr_q[BANK_ADDR_W-1:0];

        // The SP256K primitive exists only in the vendor library; simulation uses the array model.
        if (USE_SPRAM && SPRAM_EN) begin : g_spram
`ifdef SYNTHESIS
            SP256K u_spram (
                .AD      (addr),
                .DI      (sample_in),
                .MASKWE  (4'b1111),
                .WE      (we),
                .CS      (1'b1),
                .CK      (clk),
                .STDBY   (1'b0),
                .SLEEP   (1'b0),
                .PWROFF_N(1'b1),
                .DO      (bank_dout[b])
            );
`endif
        end else begin : g_array
            logic [DATA_W-1:0] mem [2**BANK_ADDR_W];
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[addr] <= sample_in;
                end else if (re) begin
                    dout_q <= mem[addr];
                end
            end
            assign bank_dout[b] = dout_q;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign length     = length_q;
    assign full       = full_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE) | rd_pend_q | out_valid_q;

endmodule

// File: doc/banked_sample_buffer.md
# banked_sample_buffer

Parametrised record/playback sample buffer built from NUM_BANKS single-port RAM banks, addressed as one linear space with the upper address bits selecting the bank. A record engine writes a stream of samples starting at address 0, and a playback engine streams back the recorded length once or in a continuous loop. It sits between the audio sample front end and the output/analysis path. It replaces fixed four-bank, externally addressed storage with self-managed pointers, length tracking and a handshake.

## Interface
- DATA_W, 16: sample width.
- NUM_BANKS, 4: bank count; power of two, ≥1.
- BANK_ADDR_W, 14: address bits per bank.
- USE_SPRAM, 1:
  - 1 instantiates SP256K per bank; requires DATA_W=16 and BANK_ADDR_W=14.
  - 0 infers a behavioural array per bank with identical 1-cycle read latency.
- Derived values:
  - ADDR_W = log2(NUM_BANKS)+BANK_ADDR_W.
  - DEPTH = 2^ADDR_W.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rec_start  in  1  pulse: begin recording at address 0.
- play_start  in  1  pulse: begin playback at address 0.
- loop  in  1  sampled at play_start; 1 = wrap to 0 after the last sample.
- stop  in  1  pulse: abort record/playback.
- in_valid  in  1  sample_in is valid this cycle (record only).
- sample_in  in  DATA_W  sample to store.
- play_req  in  1  request the next playback sample; one per cycle max.
- sample_out  out  DATA_W  registered playback sample.
- out_valid  out  1  sample_out is new this cycle (1-cycle pulse).
- length  out  ADDR_W+1  number of samples recorded (0..DEPTH).
- full  out  1  recording stopped because DEPTH was reached.
- busy  out  1  not IDLE, or playback reads still in flight.
- done  out  1  1-cycle pulse at the end of record or non-loop playback.

## Operation
- States: IDLE, RECORD, PLAY.
- Command priority is stop > rec_start > play_start.
  - rec_start/play_start are ignored unless the state is IDLE.
  - stop is ignored in IDLE.
- IDLE → RECORD on rec_start:
  - wr_ptr←0, length←0, full←0.
  - Memory is not cleared.
- RECORD: each in_valid cycle:
  - writes sample_in to bank wr_ptr[ADDR_W-1:BANK_ADDR_W], word wr_ptr[BANK_ADDR_W-1:0];
  - then wr_ptr++, length++.
  - Only the selected bank's WE is asserted; all others are held low.
- RECORD → IDLE on either of:
  - the write of address DEPTH-1: length=DEPTH, full←1, done pulse next cycle;
  - stop: length keeps its count, done pulse next cycle.
  - A stop coinciding with in_valid still commits that write.
- IDLE → PLAY on play_start with length≠0: rd_ptr←0, loop latched.
  - play_start with length=0 is ignored and the block stays IDLE.
- PLAY: each play_req cycle issues a read at rd_ptr, then rd_ptr++.
  - At rd_ptr=length-1 with loop=1: rd_ptr←0.
  - At rd_ptr=length-1 with loop=0: → IDLE after issuing the read.
- PLAY → IDLE on stop: reads already issued still complete and still produce out_valid.
- Output mux: bank select is registered with each read and applied to the bank data the next cycle, so the output is never muxed with the current-cycle address.
- done (playback) pulses together with the out_valid of the final sample when loop=0; it is not asserted for stop.
- full clears only on rec_start or reset.
- Bank outputs are not resettable; sample_out is a register loaded only on valid reads.

## Timing
- Reset values:
  - state IDLE; wr_ptr and rd_ptr 0;
  - sample_out 0, out_valid 0, length 0, full 0, busy 0, done 0.
- Reset mid-operation aborts immediately, discards in-flight reads and leaves RAM contents undefined-but-untouched. length=0 makes them unplayable.
- Write latency: sample is stored on the in_valid edge.
- Read latency: play_req in cycle N → bank output valid in N+1 → sample_out/out_valid in N+2.
  - Throughput is 1 sample/cycle with back-to-back play_req.
- busy:
  - rises in the cycle after an accepted rec_start/play_start;
  - falls in the cycle after the last out_valid, or immediately after the IDLE entry for record.
- Commands arriving in the same cycle as done are evaluated against the state for that cycle.

## Test plan
Bench configuration: USE_SPRAM=0, NUM_BANKS=4, BANK_ADDR_W=4 (DEPTH=64).
- Reset then idle → all outputs 0.
  - play_start with length=0 → stays IDLE, busy=0, no out_valid.
- rec_start, 10 in_valid samples 0x1000..0x1009, stop.
  - length=10, full=0, one done pulse.
  - play_start loop=0 with 10 back-to-back play_req: out_valid in cycles 2..11 after the first req, data 0x1000..0x1009; done with the last sample; then IDLE.
- Record 70 samples (value = index).
  - full=1 and length=64 after the 64th sample; writes 65..70 are ignored.
  - Playback returns 0..63, crossing banks at 16/32/48 with no glitch or stale-bank data.
- Record 5 samples, play_start loop=1, 12 play_req → data sequence 0,1,2,3,4,0,1,2,3,4,0,1.
  - stop after the 12th req → those 12 samples all arrive, no done pulse, busy falls afterwards.
- Priority:
  - stop+rec_start together in RECORD → stop wins, state IDLE.
  - rec_start+play_start together in IDLE → RECORD.
- Reset asserted mid-playback with reads in flight → no out_valid afterwards; length=0, busy=0.
